// File: rtl/sub_seq_ctrl.sv
// Multi-cycle wide subtractor: one SLICE-bit slice per cycle, LSB first, borrow chained in a register.
// Optional SUB_SEQ_ZERO_FLAG_EN adds o_zero, an all-zero result flag built up slice by slice.
module sub_seq_ctrl #(
    parameter int WIDTH = 256,
    parameter int SLICE = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clear,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [WIDTH-1:0] i_din1,
    input  logic [WIDTH-1:0] i_din2,
    input  logic             i_bin,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_bout
`ifdef SUB_SEQ_ZERO_FLAG_EN
    ,
    output logic             o_zero
`endif
);

    // state  | meaning
    // S_IDLE | waiting for a request, in_ready high
    // S_RUN  | subtracting slice r_cnt, borrow chained in r_borrow
    // S_DONE | result presented, waiting for out_ready
    localparam int NSLICE = WIDTH / SLICE;
    localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t            r_state;
    state_t            w_next;
    logic [WIDTH-1:0]  r_a;
    logic [WIDTH-1:0]  r_b;
    logic [WIDTH-1:0]  r_dout;
    logic              r_borrow;
    logic              r_bout;
    logic [CW-1:0]     r_cnt;
    logic [SLICE:0]    w_diff;
    logic              w_last;
    logic              w_accept;
    logic              w_step;

    // Operands shift right each cycle so the active slice is always the low SLICE bits.
    assign w_diff   = {1'b0, r_a[SLICE-1:0]} - {1'b0, r_b[SLICE-1:0]} - {{SLICE{1'b0}}, r_borrow};
    assign w_last   = (r_cnt == CW'(NSLICE - 1));
    assign w_accept = (r_state == S_IDLE) && i_in_valid && !i_clear;
    assign w_step   = (r_state == S_RUN) && !i_clear;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (i_clear) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (i_in_valid)  w_next = S_RUN;
                S_RUN:   if (w_last)      w_next = S_DONE;
                S_DONE:  if (i_out_ready) w_next = S_IDLE;
                default: w_next = S_IDLE;
            endcase
        end
    end

    // in_ready is held low for the whole time rst is asserted, not just until the next edge.
    always_comb begin
        o_in_ready  = (r_state == S_IDLE) && !rst;
        o_out_valid = (r_state == S_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a      <= '0;
            r_b      <= '0;
            r_borrow <= 1'b0;
            r_cnt    <= '0;
            r_dout   <= '0;
            r_bout   <= 1'b0;
        end else if (w_accept) begin
            r_a      <= i_din1;
            r_b      <= i_din2;
            r_borrow <= i_bin;
            r_cnt    <= '0;
        end else if (w_step) begin
            r_a      <= r_a >> SLICE;
            r_b      <= r_b >> SLICE;
            r_borrow <= w_diff[SLICE];
            r_cnt    <= r_cnt + CW'(1);
            for (int k = 0; k < NSLICE; k++) begin
                if (r_cnt == CW'(k)) r_dout[k*SLICE +: SLICE] <= w_diff[SLICE-1:0];
            end
            if (w_last) r_bout <= w_diff[SLICE];
        end
    end

    assign o_dout = r_dout;
    assign o_bout = r_bout;

`ifdef SUB_SEQ_ZERO_FLAG_EN
    logic r_zacc;
    logic r_zero;
    logic w_slice_zero;

    assign w_slice_zero = (w_diff[SLICE-1:0] == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_zacc <= 1'b0;
            r_zero <= 1'b0;
        end else if (w_accept) begin
            r_zacc <= 1'b1;
        end else if (w_step) begin
            r_zacc <= r_zacc & w_slice_zero;
            if (w_last) r_zero <= r_zacc & w_slice_zero;
        end
    end

    assign o_zero = r_zero;
`endif

endmodule
